// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer driving one shared Montgomery multiplier
module modexp_ctrl #(
    parameter int W  = 192,
    parameter int EW = 192,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exponent,
    input  logic [W-1:0]  one_m,
    output logic [W-1:0]  result,
    output logic          done,
    output logic          busy,
    output logic [W-1:0]  mm_x,
    output logic [W-1:0]  mm_y,
    output logic          mm_start,
    input  logic [W-1:0]  mm_z,
    input  logic          mm_done
);
    typedef enum logic [2:0] {IDLE, SCAN, SQR, MUL, GAP, DONE} state_t;
    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  base_r;
    logic [EW-1:0] e_sh;
    logic [CW-1:0] cnt;
    logic          pend_mul;
    logic          start_q;
    logic          mm_done_q;
    // schedule: skip leading zeros, then square (and multiply on a 1 bit) with a one-cycle gap per multiply
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            base_r    <= '0;
            e_sh      <= '0;
            cnt       <= '0;
            pend_mul  <= 1'b0;
            start_q   <= 1'b0;
            mm_done_q <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mm_start  <= 1'b0;
        end else begin
            start_q   <= start;
            mm_done_q <= mm_done;
            done      <= 1'b0;
            case (state)
                IDLE: if (start && !start_q) begin
                    base_r <= base;
                    e_sh   <= exponent;
                    acc    <= one_m;
                    cnt    <= CW'(EW);
                    busy   <= 1'b1;
                    state  <= (exponent == '0) ? DONE : SCAN;
                end
                SCAN: begin
                    e_sh <= e_sh << 1;
                    cnt  <= cnt - CW'(1);
                    if (e_sh[EW-1]) begin
                        acc      <= base_r;
                        state    <= (cnt == CW'(1)) ? DONE : SQR;
                        mm_start <= cnt != CW'(1);
                    end
                end
                SQR, MUL: if (mm_done && !mm_done_q) begin
                    acc      <= mm_z;
                    pend_mul <= (state == SQR) && e_sh[EW-1];
                    mm_start <= 1'b0;
                    state    <= GAP;
                end
                GAP: begin
                    if (pend_mul) begin
                        mm_start <= 1'b1;
                        state    <= MUL;
                    end else begin
                        e_sh     <= e_sh << 1;
                        cnt      <= cnt - CW'(1);
                        mm_start <= cnt != CW'(1);
                        state    <= (cnt == CW'(1)) ? DONE : SQR;
                    end
                end
                DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // operands are a pure decode of state and registers, so they stay put while a multiply runs
    always_comb begin
        mm_x = (state == SQR || state == MUL) ? acc : '0;
        mm_y = (state == SQR) ? acc : (state == MUL) ? base_r : '0;
    end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: randomized check of modexp_ctrl against a mod-251 mock multiplier and a modpow model
module tb_modexp_ctrl;
    localparam int W  = 192;
    localparam int EW = 192;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  base = '0;
    logic [EW-1:0] exponent = '0;
    logic [W-1:0]  one_m = '0;
    logic [W-1:0]  result;
    logic          done;
    logic          busy;
    logic [W-1:0]  mm_x;
    logic [W-1:0]  mm_y;
    logic          mm_start;
    logic [W-1:0]  mm_z;
    logic          mm_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_mul = 0;
    int n_done = 0;
    int unstable = 0;
    logic [31:0] pat = '0;
    logic        ms_d = 1'b0;
    logic [W-1:0] x_d = '0;
    logic [W-1:0] y_d = '0;
    int  mcnt = 0;
    bit  stale = 1'b0;

    modexp_ctrl #(.W(W), .EW(EW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
        .one_m(one_m), .result(result), .done(done), .busy(busy), .mm_x(mm_x),
        .mm_y(mm_y), .mm_start(mm_start), .mm_z(mm_z), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    // mock multiplier: done rises 5 cycles after mm_start rises, held until mm_start falls
    always @(posedge clk) begin
        if (!reset || !mm_start) begin
            mcnt    <= 0;
            mm_done <= stale && reset;
        end else begin
            mcnt    <= mcnt + 1;
            mm_done <= (mcnt >= 4) || (stale && mcnt == 0);
        end
    end
    assign mm_z = W'((64'(mm_x) * 64'(mm_y)) % 64'd251);

    // monitor: multiply issues, their kind (square when x==y), operand stability, done pulses
    always @(negedge clk) begin
        if (mm_start && !ms_d) begin
            n_mul++;
            pat = {pat[30:0], mm_x == mm_y};
        end
        if (mm_start && ms_d && (mm_x != x_d || mm_y != y_d)) unstable++;
        if (done) n_done++;
        ms_d = mm_start;
        x_d  = mm_x;
        y_d  = mm_y;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] om);
        longint unsigned r = 1;
        longint unsigned x = 64'(b % W'(251));
        if (e == '0) return om;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * x) % 251;
            x = (x * x) % 251;
        end
        return W'(r);
    endfunction

    function automatic int msb(input logic [EW-1:0] e);
        int k = -1;
        for (int i = 0; i < EW; i++) if (e[i]) k = i;
        return k;
    endfunction

    function automatic int ref_muls(input logic [EW-1:0] e);
        int k = msb(e);
        int pc = 0;
        if (k <= 0) return 0;
        for (int i = 0; i < k; i++) pc += int'(e[i]);
        return k + pc;
    endfunction

    // mode 0: single start pulse, 1: start held high, 2: extra start pulse while busy
    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [EW-1:0] e,
                          input logic [W-1:0] om, input int mode);
        int n0, d0, u0, cyc, exp_cyc;
        @(negedge clk);
        n0 = n_mul;
        d0 = n_done;
        u0 = unstable;
        base = b;
        exponent = e;
        one_m = om;
        start = 1'b1;
        cyc = 0;
        exp_cyc = (e == '0) ? 2 : 2 + (EW - msb(e)) + 7 * ref_muls(e);
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, ".busy"}, W'(busy), W'(1));
            if (mode != 1 && cyc == 1) start = 1'b0;
            if (mode == 2 && cyc == 20) start = 1'b1;
            if (mode == 2 && cyc == 22) start = 1'b0;
        end
        check({tag, ".cycles"}, W'(cyc), W'(exp_cyc));
        check({tag, ".result"}, result, ref_pow(b, e, om));
        repeat (mode == 1 ? 40 : 4) @(negedge clk);
        check({tag, ".ndone"}, W'(n_done - d0), W'(1));
        check({tag, ".nmul"}, W'(n_mul - n0), W'(ref_muls(e)));
        check({tag, ".idle"}, W'(busy), W'(0));
        check({tag, ".stable"}, W'(unstable - u0), W'(0));
        start = 1'b0;
    endtask

    initial begin
        logic [EW-1:0] e;
        logic [W-1:0] b;
        int n0, t;
        repeat (3) @(negedge clk);
        check("rst.result", result, W'(0));
        check("rst.done", W'(done), W'(0));
        check("rst.busy", W'(busy), W'(0));
        check("rst.mm_start", W'(mm_start), W'(0));
        check("rst.mm_x", mm_x, W'(0));
        reset = 1'b1;
        run_op("d13", W'(3), EW'(13), W'(1), 0);
        check("d13.pattern", W'(pat[4:0]), W'(5'b10110));
        run_op("e0", W'(5), EW'(0), W'(1), 0);
        run_op("e1", W'(7), EW'(1), W'(1), 0);
        run_op("ones", W'(2), '1, W'(1), 0);
        // reset during the third multiply
        @(negedge clk);
        n0 = n_mul;
        base = W'(3);
        exponent = EW'(13);
        one_m = W'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (n_mul - n0 < 3 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("midrst.reach", W'(n_mul - n0), W'(3));
        reset = 1'b0;
        @(negedge clk);
        check("midrst.busy", W'(busy), W'(0));
        check("midrst.mm_start", W'(mm_start), W'(0));
        check("midrst.result", result, W'(0));
        check("midrst.done", W'(done), W'(0));
        check("midrst.mm_x", mm_x, W'(0));
        reset = 1'b1;
        run_op("after_rst", W'(3), EW'(13), W'(1), 0);
        run_op("hold", W'(3), EW'(13), W'(1), 1);
        run_op("repulse", W'(3), EW'(13), W'(1), 2);
        stale = 1'b1;
        run_op("stale", W'(3), EW'(13), W'(1), 0);
        check("stale.pattern", W'(pat[4:0]), W'(5'b10110));
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            e = e >> $urandom_range(0, EW - 1);
            if (i == 0) e = '0;
            b = W'($urandom_range(1, 250));
            run_op($sformatf("rnd%0d", i), b, e, W'($urandom_range(1, 250)), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer that computes a modular exponentiation by driving one shared `mont_mult_modif` Montgomery multiplier through a left-to-right square-and-multiply schedule. Operands and result stay in the Montgomery domain; conversion into and out of that domain belongs to the top level. The block holds the accumulator, base and exponent registers, issues one multiply at a time, and reports a single-cycle completion pulse.

## Interface
- `W`, 192: operand/modulus width, equal to the multiplier width.
- `EW`, 192: exponent width.
- `CW`, 8: counter width; must satisfy 2^CW > EW.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request; only a rising edge sampled in IDLE starts an operation.
- `base`  in  W  base (Montgomery form); sampled at start.
- `exponent`  in  EW  exponent; sampled at start.
- `one_m`  in  W  Montgomery one, R mod N; sampled at start.
- `result`  out  W  final accumulator; holds until the next completion.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `mm_x`, `mm_y`  out  W  multiplier operands.
- `mm_start`  out  1  multiplier start level.
- `mm_z`  in  W  multiplier product.
- `mm_done`  in  1  multiplier done (`done1`).

## Operation
- Registers: `acc` (W), `base_r` (W), `e_sh` (EW, shifts left), `cnt` (CW), `pend_mul` (1), `start_q`, `mm_done_q`.
- IDLE: when `start & ~start_q`, load `base_r`, `e_sh=exponent`, `acc=one_m`, `cnt=EW`. If `exponent==0`, go to DONE. Otherwise go to SCAN.
- SCAN (skips leading zeros, one bit per cycle):
  - If `e_sh[EW-1]==0`, shift and decrement `cnt`.
  - Otherwise set `acc=base_r`, shift, decrement `cnt`, then go to DONE if the old `cnt==1`, else go to SQR.
- SQR:
  - `mm_x=mm_y=acc`, `mm_start=1`.
  - Completion is the rising edge of `mm_done` (`mm_done & ~mm_done_q`). A level that is already high is ignored.
  - On completion: `acc=mm_z`, `pend_mul=e_sh[EW-1]`, go to GAP.
- MUL:
  - `mm_x=acc`, `mm_y=base_r`, `mm_start=1`.
  - On completion: `acc=mm_z`, `pend_mul=0`, go to GAP.
- GAP: `mm_start=0` for exactly one cycle.
  - If `pend_mul`, go to MUL.
  - Otherwise shift `e_sh`, decrement `cnt`, then go to DONE if the old `cnt==1`, else go to SQR.
- DONE: `result=acc`, `done=1` for one cycle, then IDLE.
- Multiply count: exponent MSB at index k gives k squarings plus popcount(exponent[k-1:0]) multiplies. Exponents 0 and 1 issue no multiply.
- `mm_x`/`mm_y` are decoded from state and registers. They are stable for the whole time `mm_start` is high.
- Start handling: a `start` edge while `busy` is ignored. A `start` held high does not retrigger.

## Timing
- Reset (`reset==0` at a clock edge) applies on the next edge, including mid-operation:
  - state=IDLE; `result=0`, `done=0`, `busy=0`, `mm_start=0`, `mm_x=mm_y=0`.
  - All internal registers are cleared.
  - The multiplier is reset by the same signal.
- Cycle counts:
  - Start edge to leaving IDLE: 1 cycle.
  - SCAN: EW−k cycles.
  - Each multiply: from `mm_start` rise until the edge-detected done, plus 1 GAP cycle.
  - DONE: 1 cycle.
- Exponent 0 completes with `done` 2 cycles after the start edge, and `result=one_m`.
- `mm_start` always falls for at least one cycle between consecutive multiplies.
- `result` changes only in DONE and on reset.

## Test plan
All scenarios use a mock multiplier with `z=x·y mod 251`, done rising 5 cycles after `mm_start` rises and held until `mm_start` falls, and `one_m=1`.
- `base=3`, `exponent=0xD` -> `result=222`, exactly 5 `mm_start` pulses (S, M, S, S, M), `done` high exactly one cycle, `busy` low afterwards.
- `exponent=0` -> `result=1`, no `mm_start`, `done` 2 cycles after the start edge. `exponent=1`, `base=7` -> `result=7`, no `mm_start`.
- `exponent=2^EW−1`, `base=2` -> 191 squarings and 191 multiplies; `result` equals the bench's reference `pow(2, 2^192−1, 251)`.
- Pull `reset` low during the 3rd multiply -> the next cycle shows `busy=0`, `mm_start=0`, `result=0`. A new start with `base=3`, `exponent=0xD` then yields 222.
- Hold `start` high throughout and pulse it again while busy -> exactly one operation runs.
- Stale done: the mock holds `mm_done=1` at issue, drops it, then raises it -> the controller waits for that later rise, and `result` is still 222.
